// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token symbols, alignment FSM states and the
// 10b->8b data decode used by the receive channel.
package tmds_pkg;

    // Control tokens as they appear on the wire, bits 9..0; identical to the
    // transmit-side encoder constants.
    localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SLIP   = 2'd1,
        LOCKED = 2'd2
    } align_state_t;

    // Undo the optional inversion (bit 9), then the XOR/XNOR chain (bit 8).
    function automatic logic [7:0] tmds_decode(input logic [9:0] q);
        logic [7:0] v;
        logic [7:0] d;
        v    = q[9] ? ~q[7:0] : q[7:0];
        d    = '0;
        d[0] = v[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = q[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
        end
        return d;
    endfunction

endpackage

// File: rtl/tmds_rx_channel_if.sv
// Symbol/pixel bundle between a deserializer-side master and the TMDS receive
// channel. Stats counters exist only when TMDS_RX_STATS_EN is defined.
interface tmds_rx_channel_if;
    logic [9:0] word;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       de;
    logic       bitslip;
    logic       locked;
`ifdef TMDS_RX_STATS_EN
    logic [7:0] slip_cnt;
    logic [7:0] loss_cnt;
`endif

    modport master (
        output word,
        input  data, ctrl, de, bitslip, locked
`ifdef TMDS_RX_STATS_EN
        , input slip_cnt, loss_cnt
`endif
    );

    modport slave (
        input  word,
        output data, ctrl, de, bitslip, locked
`ifdef TMDS_RX_STATS_EN
        , output slip_cnt, loss_cnt
`endif
    );
endinterface

// File: rtl/tmds_align_fsm.sv
// Word-alignment state machine: hunts for control-token runs, requests bitslips
// on timeout and tracks lock. Optional counters under TMDS_RX_STATS_EN.
module tmds_align_fsm
    import tmds_pkg::*;
#(
    parameter int CTRL_LOCK = 8,
    parameter int TIMEOUT   = 4096,
    parameter int SLIP_WAIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_is_ctrl,
    output logic       o_lock_next,
    output logic       o_locked,
    output logic       o_bitslip
`ifdef TMDS_RX_STATS_EN
    ,
    output logic [7:0] o_slip_cnt,
    output logic [7:0] o_loss_cnt
`endif
);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int RUN_W = $clog2(CTRL_LOCK + 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] SLIP_LAST = TMR_W'(SLIP_WAIT - 1);
    localparam logic [RUN_W-1:0] RUN_FULL  = RUN_W'(CTRL_LOCK);

    align_state_t     r_state;
    logic [TMR_W-1:0] r_tmr;
    logic [RUN_W-1:0] r_run;
    logic             r_locked;
    logic             r_bitslip;
    logic             w_timeout;

    assign w_timeout = (r_tmr == TMR_LAST);

    // Lock state after the coming edge; lets the output stage gate on the same edge.
    assign o_lock_next = ((r_state == SEARCH) && (r_run == RUN_FULL)) ||
                         ((r_state == LOCKED) && (i_is_ctrl || !w_timeout));
    assign o_locked    = r_locked;
    assign o_bitslip   = r_bitslip;

`ifdef TMDS_RX_STATS_EN
    logic [7:0] r_slip_cnt;
    logic [7:0] r_loss_cnt;
    assign o_slip_cnt = r_slip_cnt;
    assign o_loss_cnt = r_loss_cnt;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= SEARCH;
            r_tmr     <= '0;
            r_run     <= '0;
            r_locked  <= 1'b0;
            r_bitslip <= 1'b0;
`ifdef TMDS_RX_STATS_EN
            r_slip_cnt <= '0;
            r_loss_cnt <= '0;
`endif
        end else begin
            r_bitslip <= 1'b0;
            case (r_state)
                SEARCH: begin
                    // A completed token run wins over a timeout on the same edge.
                    if (r_run == RUN_FULL) begin
                        r_state  <= LOCKED;
                        r_locked <= 1'b1;
                        r_tmr    <= '0;
                        r_run    <= '0;
                    end else begin
                        r_run <= i_is_ctrl ? r_run + RUN_W'(1) : '0;
                        if (w_timeout) begin
                            r_state   <= SLIP;
                            r_bitslip <= 1'b1;
                            r_tmr     <= '0;
`ifdef TMDS_RX_STATS_EN
                            if (r_slip_cnt != 8'hFF) r_slip_cnt <= r_slip_cnt + 8'd1;
`endif
                        end else begin
                            r_tmr <= r_tmr + TMR_W'(1);
                        end
                    end
                end
                SLIP: begin
                    if (r_tmr == SLIP_LAST) begin
                        r_state <= SEARCH;
                        r_tmr   <= '0;
                        r_run   <= '0;
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end
                LOCKED: begin
                    if (i_is_ctrl) begin
                        r_tmr <= '0;
                    end else if (w_timeout) begin
                        r_state  <= SEARCH;
                        r_locked <= 1'b0;
                        r_tmr    <= '0;
                        r_run    <= '0;
`ifdef TMDS_RX_STATS_EN
                        if (r_loss_cnt != 8'hFF) r_loss_cnt <= r_loss_cnt + 8'd1;
`endif
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end
                default: r_state <= SEARCH;
            endcase
        end
    end
endmodule

// File: rtl/tmds_rx_channel.sv
// TMDS receive channel: two-stage decode pipeline plus word alignment.
// Define TMDS_RX_STATS_EN to expose slip/loss counters on the interface.
module tmds_rx_channel
    import tmds_pkg::*;
#(
    parameter int CTRL_LOCK = 8,
    parameter int TIMEOUT   = 4096,
    parameter int SLIP_WAIT = 16
) (
    input logic              clk,
    input logic              rst,
    tmds_rx_channel_if.slave bus
);
    logic [9:0] r_word;
    logic [7:0] r_data;
    logic [1:0] r_ctrl;
    logic       r_de;
    logic       w_is_ctrl;
    logic [1:0] w_ctrl_val;
    logic [7:0] w_dec;
    logic       w_lock_next;

    always_comb begin
        w_is_ctrl  = 1'b1;
        w_ctrl_val = 2'b00;
        case (r_word)
            CTRL_TOKEN_00: w_ctrl_val = 2'b00;
            CTRL_TOKEN_01: w_ctrl_val = 2'b01;
            CTRL_TOKEN_10: w_ctrl_val = 2'b10;
            CTRL_TOKEN_11: w_ctrl_val = 2'b11;
            default:       w_is_ctrl  = 1'b0;
        endcase
    end

    assign w_dec = tmds_decode(r_word);

    tmds_align_fsm #(
        .CTRL_LOCK (CTRL_LOCK),
        .TIMEOUT   (TIMEOUT),
        .SLIP_WAIT (SLIP_WAIT)
    ) u_align (
        .clk         (clk),
        .rst         (rst),
        .i_is_ctrl   (w_is_ctrl),
        .o_lock_next (w_lock_next),
        .o_locked    (bus.locked),
        .o_bitslip   (bus.bitslip)
`ifdef TMDS_RX_STATS_EN
        ,
        .o_slip_cnt  (bus.slip_cnt),
        .o_loss_cnt  (bus.loss_cnt)
`endif
    );

    // Tokens leave data untouched and data words leave ctrl untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word <= '0;
            r_data <= '0;
            r_ctrl <= '0;
            r_de   <= 1'b0;
        end else begin
            r_word <= bus.word;
            if (!w_lock_next) begin
                r_data <= '0;
                r_ctrl <= '0;
                r_de   <= 1'b0;
            end else if (w_is_ctrl) begin
                r_ctrl <= w_ctrl_val;
                r_de   <= 1'b0;
            end else begin
                r_data <= w_dec;
                r_de   <= 1'b1;
            end
        end
    end

    assign bus.data = r_data;
    assign bus.ctrl = r_ctrl;
    assign bus.de   = r_de;
endmodule

// File: tb/tb_tmds_rx_channel.sv
// Randomized bench for tmds_rx_channel against an encoder-based reference model.
`timescale 1ns/1ps
module tb_tmds_rx_channel;
    localparam int CL = 8;
    localparam int TO = 64;
    localparam int SW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tmds_rx_channel_if bus();

    tmds_rx_channel #(.CTRL_LOCK(CL), .TIMEOUT(TO), .SLIP_WAIT(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [9:0] tok_tbl [4] = '{10'b1101010100, 10'b0010101011,
                                10'b0101010100, 10'b1010101011};

    // Reference model: mode 0 hunting, 1 waiting after slip, 2 aligned.
    int         m_mode, m_age, m_tok_run, m_since_tok;
    logic [9:0] m_prev_w;
    logic [7:0] m_prev_b;
    logic [7:0] e_data;
    logic [1:0] e_ctrl;
    logic       e_de, e_bitslip, e_locked;
    int         e_slip_cnt, e_loss_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int tok_index(input logic [9:0] w);
        for (int k = 0; k < 4; k++) if (tok_tbl[k] == w) return k;
        return -1;
    endfunction

    function automatic logic [9:0] encode(input logic [7:0] b, input bit use_xnor, input bit inv);
        logic [7:0] qm;
        qm[0] = b[0];
        for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ b[i]) : (qm[i-1] ^ b[i]);
        return {inv, ~use_xnor, inv ? ~qm : qm};
    endfunction

    function automatic logic [9:0] rotl(input logic [9:0] x, input int n);
        logic [19:0] t;
        t = {x, x} << n;
        return t[19:10];
    endfunction

    task automatic model_reset();
        m_mode = 0; m_age = 0; m_tok_run = 0; m_since_tok = 0;
        m_prev_w = '0; m_prev_b = '0;
        e_data = '0; e_ctrl = '0; e_de = 1'b0; e_bitslip = 1'b0; e_locked = 1'b0;
        e_slip_cnt = 0; e_loss_cnt = 0;
    endtask

    // One clock edge: the previously registered word is consumed.
    task automatic model_edge();
        int t;
        t = tok_index(m_prev_w);
        e_bitslip = 1'b0;
        if (m_mode == 0) begin
            if (m_tok_run >= CL) begin
                m_mode = 2; m_since_tok = 0;
            end else begin
                m_tok_run = (t >= 0) ? m_tok_run + 1 : 0;
                m_age++;
                if (m_age == TO) begin
                    m_mode = 1; m_age = 0; e_bitslip = 1'b1;
                    if (e_slip_cnt < 255) e_slip_cnt++;
                end
            end
        end else if (m_mode == 1) begin
            m_age++;
            if (m_age == SW) begin m_mode = 0; m_age = 0; m_tok_run = 0; end
        end else begin
            if (t >= 0) m_since_tok = 0;
            else begin
                m_since_tok++;
                if (m_since_tok == TO) begin
                    m_mode = 0; m_age = 0; m_tok_run = 0;
                    if (e_loss_cnt < 255) e_loss_cnt++;
                end
            end
        end
        e_locked = (m_mode == 2);
        if (!e_locked) begin
            e_data = '0; e_ctrl = '0; e_de = 1'b0;
        end else if (t >= 0) begin
            e_ctrl = 2'(t); e_de = 1'b0;
        end else begin
            e_data = m_prev_b; e_de = 1'b1;
        end
    endtask

    task automatic check_all(input string pfx);
        chk({pfx, "_data"},    32'(bus.data),    32'(e_data));
        chk({pfx, "_ctrl"},    32'(bus.ctrl),    32'(e_ctrl));
        chk({pfx, "_de"},      32'(bus.de),      32'(e_de));
        chk({pfx, "_bitslip"}, 32'(bus.bitslip), 32'(e_bitslip));
        chk({pfx, "_locked"},  32'(bus.locked),  32'(e_locked));
`ifdef TMDS_RX_STATS_EN
        chk({pfx, "_slip_cnt"}, 32'(bus.slip_cnt), 32'(e_slip_cnt));
        chk({pfx, "_loss_cnt"}, 32'(bus.loss_cnt), 32'(e_loss_cnt));
`endif
    endtask

    task automatic step(input logic [9:0] w, input logic [7:0] b);
        bus.word = w;
        @(posedge clk);
        #1;
        cyc++;
        model_edge();
        m_prev_w = w;
        m_prev_b = b;
        check_all("step");
    endtask

    task automatic send_tok(input int k);
        step(tok_tbl[k], 8'h00);
    endtask

    task automatic send_data(input logic [7:0] b, input bit use_xnor, input bit inv);
        step(encode(b, use_xnor, inv), b);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.word = '0;
        model_reset();
        #1;
        check_all("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int first_lock;
        int off;
        int pulses [$];
        logic [7:0] bytes [4];
        bytes = '{8'h00, 8'hFF, 8'hA5, 8'h10};
        bus.word = '0;

        // Initial lock: lock must be visible on the 10th step after the first token.
        do_reset();
        first_lock = -1;
        for (int i = 1; i <= 14; i++) begin
            if (i <= 8) send_tok(0); else send_data(8'h3C, 1'b0, 1'b0);
            if (i <= 9) chk("tok_de", 32'(bus.de), 32'd0);
            if (bus.locked && first_lock < 0) first_lock = i;
        end
        chk("lock_cycle", 32'(first_lock), 32'd10);
        chk("lock_ctrl", 32'(bus.ctrl), 32'd0);

        // Directed bytes in all four encoder variants, token between each.
        for (int i = 0; i < 4; i++) begin
            for (int v = 0; v < 4; v++) begin
                send_data(bytes[i], v[0], v[1]);
                send_tok(v);
            end
        end
        for (int i = 0; i < 4; i++) begin
            send_data(bytes[i], 1'b1, 1'b0);
            send_data(8'h00, 1'b0, 1'b0);
            chk("byte_out", 32'(bus.data), 32'(bytes[i]));
            chk("byte_de", 32'(bus.de), 32'd1);
        end

        // Random mix of tokens and encoded bytes while aligned.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3) == 0) send_tok(int'($urandom_range(3)));
            else send_data(8'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        // Loss of lock after TO token-free words.
        do_reset();
        repeat (8) send_tok(2);
        send_tok(2);
        for (int i = 0; i < TO; i++) send_data(8'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)));
        chk("to_hold", 32'(bus.locked), 32'd1);
        send_data(8'h55, 1'b0, 1'b0);
        chk("to_fall", 32'(bus.locked), 32'd0);
        for (int i = 0; i < 4; i++) begin
            send_data(8'($urandom), 1'b0, 1'b1);
            chk("to_de", 32'(bus.de), 32'd0);
        end
`ifdef TMDS_RX_STATS_EN
        chk("to_loss_cnt", 32'(bus.loss_cnt), 32'd1);
`endif

        // Broken run: 7 tokens, a data word, then 8 tokens.
        do_reset();
        first_lock = -1;
        for (int i = 1; i <= 22; i++) begin
            if (i <= 7 || (i >= 9 && i <= 16)) send_tok(1);
            else send_data(8'h81, 1'b0, 1'b0);
            if (bus.locked && first_lock < 0) first_lock = i;
        end
        chk("rerun_lock_cycle", 32'(first_lock), 32'd18);

        // Misaligned stream: rotator backs off one bit per bitslip.
        do_reset();
        off = 3;
        pulses.delete();
        for (int i = 0; i < 4 * (TO + SW) + 40; i++) begin
            step(rotl(tok_tbl[0], off), 8'h00);
            if (bus.bitslip) begin
                pulses.push_back(cyc);
                off = (off == 0) ? 9 : off - 1;
            end
        end
        chk("rot_pulses", 32'(pulses.size()), 32'd3);
        if (pulses.size() >= 3) begin
            chk("rot_space1", 32'(pulses[1] - pulses[0]), 32'(TO + SW));
            chk("rot_space2", 32'(pulses[2] - pulses[1]), 32'(TO + SW));
        end
        chk("rot_locked", 32'(bus.locked), 32'd1);

        // Asynchronous reset while locked with non-zero data on the outputs.
        do_reset();
        repeat (8) send_tok(3);
        send_data(8'hA5, 1'b0, 1'b0);
        send_data(8'hA5, 1'b1, 1'b1);
        chk("pre_rst_data", 32'(bus.data), 32'hA5);
        rst = 1'b0;
        #1;
        chk("arst_data",    32'(bus.data),    32'd0);
        chk("arst_ctrl",    32'(bus.ctrl),    32'd0);
        chk("arst_de",      32'(bus.de),      32'd0);
        chk("arst_bitslip", 32'(bus.bitslip), 32'd0);
        chk("arst_locked",  32'(bus.locked),  32'd0);
        do_reset();
        repeat (8) send_tok(3);
        send_data(8'h42, 1'b0, 1'b1);
        send_data(8'h99, 1'b1, 1'b0);
        chk("relock", 32'(bus.locked), 32'd1);
        send_data(8'h00, 1'b0, 1'b0);
        chk("relock_data", 32'(bus.data), 32'h99);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/tmds_rx_channel.md
# tmds_rx_channel

Receive-side counterpart of the HDMI/DVI TMDS transmit path. The block takes one 10-bit TMDS symbol per pixel clock from an external deserializer and decodes it to 8-bit pixel data, 2-bit control and data-enable. It word-aligns the deserializer by pulsing `bitslip` until control-token runs are detected, and it reports lock. One instance is used per TMDS channel; channel 0 carries hsync/vsync in its `ctrl` output.

## Interface
- `CTRL_LOCK`, 8: consecutive control tokens required to declare lock.
- `TIMEOUT`, 4096: maximum number of words without lock (SEARCH) or without a control token (LOCKED) before action is taken. Must exceed one line length (1650 at 720p).
- `SLIP_WAIT`, 16: words to wait after a `bitslip` pulse before searching again.
- `clk` in 1: pixel clock; one symbol per cycle.
- `rst` in 1: asynchronous, active-low reset.
- `word` in 10: TMDS symbol; bit 0 is the first bit on the wire.
- `data` out 8: decoded pixel byte.
- `ctrl` out 2: decoded control bits {C1,C0}.
- `de` out 1: data enable.
- `bitslip` out 1: one-cycle request to the deserializer to shift alignment by one bit.
- `locked` out 1: channel aligned.

## Operation
- Stage 1 registers `word`.
- Stage 2 classifies and decodes the registered word:
  - Control tokens (bits 9..0): 1101010100 gives ctrl=00; 0010101011 gives 01; 0101010100 gives 10; 1010101011 gives 11.
  - Data decode: let q = word. If q[9]=1, first invert q[7:0]. Then d[0]=q[0], and for i=1..7: d[i]=q[i]^q[i-1] when q[8]=1, otherwise ~(q[i]^q[i-1]).
- Outputs while locked:
  - Control token: de=0, ctrl=token value, data held at its previous value.
  - Any other word: de=1, data=decoded byte, ctrl held.
- Outputs while not locked: de=0, data=0, ctrl=0.
- FSM states: SEARCH, SLIP, LOCKED. Reset state is SEARCH.
  - SEARCH: `run` increments on each control token and clears on any other word. When `run` reaches CTRL_LOCK, go to LOCKED. Otherwise `tmr` increments every word; at `tmr`=TIMEOUT-1, go to SLIP.
  - SLIP: `bitslip`=1 for the first cycle only. Stay in SLIP for SLIP_WAIT cycles in total, then go to SEARCH with `run` and `tmr` cleared.
  - LOCKED: `tmr` clears on every control token and increments otherwise. At `tmr`=TIMEOUT-1, go to SEARCH with `run` and `tmr` cleared.
- Simultaneous events: lock detection takes priority over timeout on the same cycle.
- Counter widths: `$clog2(TIMEOUT+1)` for `tmr`, `$clog2(CTRL_LOCK+1)` for `run`. Neither counter wraps.

## Timing
- Reset values: data=0, ctrl=0, de=0, bitslip=0, locked=0, FSM=SEARCH, all counters 0.
- Data latency: a symbol presented on `word` at cycle n appears on data/ctrl/de at cycle n+2.
- FSM latency: the FSM consumes the stage-1 word. `locked` rises 1 cycle after the CTRL_LOCK-th consecutive token is registered, and falls in the same relation to the timeout.
- `locked` and de gating switch on the same edge as the FSM transition.
- `bitslip` is exactly one cycle high per SLIP entry. It never pulses more than once per SLIP_WAIT+TIMEOUT window.
- Reset asserted mid-operation forces all reset values immediately (asynchronous). Operation restarts in SEARCH on the first edge after release.

## Configuration
- Macro `TMDS_RX_STATS_EN`, when defined, adds two output ports:
  - `slip_cnt[7:0]`: counts `bitslip` pulses.
  - `loss_cnt[7:0]`: counts LOCKED to SEARCH transitions.
  - Both saturate at 255 and are cleared only by `rst`.
- When the macro is undefined, those ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package `tmds_pkg`:
  - The four control-token localparams.
  - FSM state enum: SEARCH, SLIP, LOCKED.
  - A `tmds_decode` function mapping 10 bits to 8 bits.
- This block's symbol values must match the encoder constants used by the transmit `hdmi` path.
- Sub-module: `tmds_align_fsm`, containing the state machine, counters and the optional stats. The parent keeps the pipeline registers and the decode logic.

## Test plan
- Reset, then 8 words of 1101010100 followed by data: locked=1 at cycle 10 after the first token; ctrl=00; de=0 during the tokens.
- Encoded bytes 0x00, 0xFF, 0xA5 and 0x10 (both q[9] and q[8] variants) after lock: data equals each byte 2 cycles later, with de=1.
- Token stream rotated by 3 bits (feeds the TB bit-rotator model): exactly 3 bitslip pulses, spaced TIMEOUT+SLIP_WAIT words apart, then lock.
- Locked, then TIMEOUT data words with no token: locked falls; de=0 thereafter. With `TMDS_RX_STATS_EN`, loss_cnt=1.
- 7 tokens, 1 data word, 8 tokens: no lock after the first 7; lock only after the 8th token of the second run.
- rst pulsed low while locked: all outputs are 0 within the same cycle, and the block relocks after 8 tokens.
